// File: rtl/float16_pkg.sv
// float16_pkg: binary16 field positions and float_max_sched FSM state encodings
package float16_pkg;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_MSB  = 9;
    localparam int MAN_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/float16_gt.sv
// float16_gt: combinational binary16 strict greater-than; NaN/inf ordered by bit pattern
module float16_gt
    import float16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt
);
    logic [14:0] ma, mb;

    always_comb begin
        ma = {a[EXP_MSB:EXP_LSB], a[MAN_MSB:MAN_LSB]};
        mb = {b[EXP_MSB:EXP_LSB], b[MAN_MSB:MAN_LSB]};
        // +0 and -0 compare equal, so a sign difference alone is not enough
        gt = (a[SIGN_BIT] != b[SIGN_BIT]) ? (!a[SIGN_BIT] && (ma != '0 || mb != '0))
           : a[SIGN_BIT] ? (ma < mb) : (ma > mb);
    end
endmodule

// File: rtl/float_max_sched.sv
// float_max_sched: streams a burst of binary16 values and reports the maximum and its first index
module float_max_sched
    import float16_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf
);
    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [15:0]      max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             gt, in_xfer, out_xfer, first, sat;

    float16_gt u_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (gt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == DONE) ? (out_xfer ? IDLE : DONE)
                : (in_xfer ? (in_last ? DONE : ACCUM) : state_q);
    end

    always_comb begin
        in_ready  = !rst && state_q != DONE;
        out_valid = !rst && state_q == DONE;
        out_max   = rst ? '0 : max_q;
        out_idx   = rst ? '0 : idx_q;
        out_ovf   = !rst && ovf_q;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // cnt_q is the index of the element being accepted; its MSB marks saturation at 2**IDX_W
    always_comb begin
        first = state_q == IDLE;
        sat   = cnt_q[IDX_W];
        max_d = (in_xfer && (first || gt)) ? in_data : max_q;
        idx_d = !in_xfer ? idx_q : first ? '0 : (gt && !sat) ? cnt_q[IDX_W-1:0] : idx_q;
        cnt_d = !in_xfer ? cnt_q : first ? CNT_ONE : sat ? cnt_q : cnt_q + CNT_ONE;
        ovf_d = !in_xfer ? ovf_q : !first && (ovf_q || sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_float_max_sched.sv
// tb_float_max_sched: directed checks of max/index search, backpressure, overflow and reset abort
module tb_float_max_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_max;
    logic [7:0]  out_idx;
    logic        o2_in_ready, o2_out_valid, o2_out_ovf;
    logic [15:0] o2_out_max;
    logic [1:0]  o2_out_idx;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    float_max_sched #(.IDX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_idx(out_idx), .out_ovf(out_ovf)
    );

    float_max_sched #(.IDX_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(o2_out_valid), .out_ready(out_ready), .out_max(o2_out_max),
        .out_idx(o2_out_idx), .out_ovf(o2_out_ovf)
    );

    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_max, out_idx, out_ovf} !== 25'd0) begin bad++; $display("FAIL rst_outputs got=%h/%h/%b exp=0", out_max, out_idx, out_ovf); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        send(16'h3800, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_max !== 16'h4000) begin bad++; $display("FAIL basic_max got=%h exp=4000", out_max); end
        total++; if (out_idx !== 8'd1) begin bad++; $display("FAIL basic_idx got=%0d exp=1", out_idx); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_in_ready got=%b exp=0", in_ready); end
        consume();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_negative();
        send(16'hC000, 1'b0);
        send(16'hBC00, 1'b0);
        send(16'hC400, 1'b1);
        total++; if (out_max !== 16'hBC00) begin bad++; $display("FAIL neg_max got=%h exp=BC00", out_max); end
        total++; if (out_idx !== 8'd1) begin bad++; $display("FAIL neg_idx got=%0d exp=1", out_idx); end
        consume();
        send(16'h8000, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_max !== 16'h8000) begin bad++; $display("FAIL single_max got=%h exp=8000", out_max); end
        total++; if (out_idx !== 8'd0) begin bad++; $display("FAIL single_idx got=%0d exp=0", out_idx); end
        consume();
    endtask

    task automatic test_ties();
        send(16'h4200, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h8000, 1'b1);
        total++; if (out_max !== 16'h4200) begin bad++; $display("FAIL tie_max got=%h exp=4200", out_max); end
        total++; if (out_idx !== 8'd0) begin bad++; $display("FAIL tie_idx got=%0d exp=0", out_idx); end
        consume();
        send(16'h8000, 1'b0);
        send(16'h0000, 1'b1);
        total++; if (out_max !== 16'h8000) begin bad++; $display("FAIL zero_max got=%h exp=8000", out_max); end
        total++; if (out_idx !== 8'd0) begin bad++; $display("FAIL zero_idx got=%0d exp=0", out_idx); end
        consume();
    endtask

    task automatic test_backpressure();
        send(16'h4000, 1'b0);
        send(16'h4400, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h7000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hs_%0d got=%b/%b exp=0/1", i, in_ready, out_valid); end
            total++; if (out_max !== 16'h4400 || out_idx !== 8'd1 || out_ovf !== 1'b0) begin bad++; $display("FAIL bp_data_%0d got=%h/%0d/%b exp=4400/1/0", i, out_max, out_idx, out_ovf); end
            @(posedge clk); #1;
        end
        consume();
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_accept_on_out got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        total++; if (o2_out_valid !== 1'b1 || o2_out_max !== 16'h4000) begin bad++; $display("FAIL full_max got=%b/%h exp=1/4000", o2_out_valid, o2_out_max); end
        total++; if (o2_out_idx !== 2'd3 || o2_out_ovf !== 1'b0) begin bad++; $display("FAIL full_idx_ovf got=%0d/%b exp=3/0", o2_out_idx, o2_out_ovf); end
        consume();
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h4400, 1'b0);
        send(16'h7BFF, 1'b1);
        total++; if (o2_out_max !== 16'h7BFF) begin bad++; $display("FAIL ovf_max got=%h exp=7BFF", o2_out_max); end
        total++; if (o2_out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", o2_out_ovf); end
        total++; if (o2_out_idx !== 2'd2) begin bad++; $display("FAIL ovf_idx got=%0d exp=2", o2_out_idx); end
        total++; if (out_max !== 16'h7BFF || out_idx !== 8'd5 || out_ovf !== 1'b0) begin bad++; $display("FAIL wide_result got=%h/%0d/%b exp=7BFF/5/0", out_max, out_idx, out_ovf); end
        consume();
        send(16'h3800, 1'b1);
        total++; if (o2_out_ovf !== 1'b0 || o2_out_max !== 16'h3800) begin bad++; $display("FAIL ovf_cleared got=%b/%h exp=0/3800", o2_out_ovf, o2_out_max); end
        consume();
    endtask

    task automatic test_abort();
        send(16'h4800, 1'b0);
        send(16'h4400, 1'b0);
        rst = 1'b1;
        #1;
        total++; if (out_max !== 16'h0000 || in_ready !== 1'b0) begin bad++; $display("FAIL abort_rst_out got=%h/%b exp=0000/0", out_max, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_ghost_%0d got=%b exp=0", i, out_valid); end
            @(posedge clk); #1;
        end
        send(16'h3C00, 1'b1);
        total++; if (out_valid !== 1'b1 || out_max !== 16'h3C00) begin bad++; $display("FAIL abort_max got=%b/%h exp=1/3C00", out_valid, out_max); end
        total++; if (out_idx !== 8'd0 || out_ovf !== 1'b0) begin bad++; $display("FAIL abort_idx got=%0d/%b exp=0/0", out_idx, out_ovf); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ties();
        test_backpressure();
        test_overflow();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
